// File: rtl/cam_project_3d2d.sv
// rtl/cam_project_3d2d.sv - FSM-sequenced pinhole projector with loadable intrinsics, serial divide and clamping
module cam_project_3d2d #(
    parameter int XY_W  = 32,
    parameter int Z_W   = 16,
    parameter int K_W   = 10,
    parameter int SCALE = 1,
    parameter int RATE  = 1,
    parameter int IMG_W = 480,
    parameter int IMG_H = 320,
    parameter int OUT_W = 16,
    parameter int FX    = 437,
    parameter int SK    = 0,
    parameter int CX    = 242,
    parameter int FY    = 330,
    parameter int CY    = 145
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [XY_W-1:0] in_x,
    input  logic signed [XY_W-1:0] in_y,
    input  logic signed [Z_W-1:0]  in_z,
    input  logic                   cfg_we,
    input  logic [2:0]             cfg_addr,
    input  logic [K_W-1:0]         cfg_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_x,
    output logic [OUT_W-1:0]       out_y,
    output logic [1:0]             out_stat
);
    localparam int NUM_W = K_W + XY_W + Z_W + 4;
    localparam int CNT_W = $clog2(NUM_W) + 1;
    localparam logic signed [NUM_W-1:0] LP_SCALE = NUM_W'(SCALE);
    localparam logic signed [NUM_W-1:0] LP_RATE  = NUM_W'(RATE);
    localparam logic signed [NUM_W-1:0] LP_XMAX  = NUM_W'(IMG_W - 1);
    localparam logic signed [NUM_W-1:0] LP_YMAX  = NUM_W'(IMG_H - 1);

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_DIV, S_POST, S_HOLD} state_t;
    state_t r_state, w_next;

    logic [K_W-1:0] r_fx, r_sk, r_cx, r_fy, r_cy;
    logic [K_W-1:0] r_s_fx, r_s_sk, r_s_cx, r_s_fy, r_s_cy;
    logic signed [XY_W-1:0] r_x, r_y;
    logic signed [Z_W-1:0]  r_z;
    logic [NUM_W-1:0] r_qx, r_qy;
    logic [Z_W-1:0]   r_rx, r_ry, r_d;
    logic             r_negx, r_negy, r_bad;
    logic [CNT_W-1:0] r_cnt;
    logic [OUT_W-1:0] r_out_x, r_out_y;
    logic [1:0]       r_out_stat;

    logic signed [NUM_W-1:0] w_x, w_y, w_z, w_fx, w_sk, w_cx, w_fy, w_cy, w_nx, w_ny;
    logic signed [NUM_W-1:0] w_vx, w_vy;
    logic [Z_W:0]     w_tx, w_ty;
    logic             w_gex, w_gey, w_zbad, w_clx, w_cly;
    logic [OUT_W-1:0] w_cxo, w_cyo;

    assign w_x  = {{(NUM_W-XY_W){r_x[XY_W-1]}}, r_x};
    assign w_y  = {{(NUM_W-XY_W){r_y[XY_W-1]}}, r_y};
    assign w_z  = {{(NUM_W-Z_W){r_z[Z_W-1]}}, r_z};
    assign w_fx = {{(NUM_W-K_W){1'b0}}, r_s_fx};
    assign w_sk = {{(NUM_W-K_W){1'b0}}, r_s_sk};
    assign w_cx = {{(NUM_W-K_W){1'b0}}, r_s_cx};
    assign w_fy = {{(NUM_W-K_W){1'b0}}, r_s_fy};
    assign w_cy = {{(NUM_W-K_W){1'b0}}, r_s_cy};
    assign w_nx = (w_fx * w_x + w_sk * w_y + w_cx * w_z) * LP_SCALE;
    assign w_ny = (w_fy * w_y + w_cy * w_z) * LP_SCALE;
    assign w_zbad = r_z[Z_W-1] || (r_z == '0);

    // One restoring step per axis: shift in the next dividend bit, subtract if it fits.
    assign w_tx  = {r_rx, r_qx[NUM_W-1]};
    assign w_ty  = {r_ry, r_qy[NUM_W-1]};
    assign w_gex = w_tx >= {1'b0, r_d};
    assign w_gey = w_ty >= {1'b0, r_d};

    assign w_vx = (r_negx ? -$signed(r_qx) : $signed(r_qx)) * LP_RATE;
    assign w_vy = (r_negy ? -$signed(r_qy) : $signed(r_qy)) * LP_RATE;

    always_comb begin
        w_cxo = w_vx[OUT_W-1:0];
        w_clx = 1'b0;
        if (w_vx < 0) begin
            w_cxo = '0;
            w_clx = 1'b1;
        end else if (w_vx > LP_XMAX) begin
            w_cxo = LP_XMAX[OUT_W-1:0];
            w_clx = 1'b1;
        end
        w_cyo = w_vy[OUT_W-1:0];
        w_cly = 1'b0;
        if (w_vy < 0) begin
            w_cyo = '0;
            w_cly = 1'b1;
        end else if (w_vy > LP_YMAX) begin
            w_cyo = LP_YMAX[OUT_W-1:0];
            w_cly = 1'b1;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_MAC;
            end
            S_MAC:  w_next = w_zbad ? S_POST : S_DIV;
            S_DIV:  if (r_cnt == CNT_W'(NUM_W - 1)) w_next = S_POST;
            S_POST: w_next = S_HOLD;
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fx <= K_W'(FX);
            r_sk <= K_W'(SK);
            r_cx <= K_W'(CX);
            r_fy <= K_W'(FY);
            r_cy <= K_W'(CY);
        end else if (cfg_we) begin
            case (cfg_addr)
                3'd0:    r_fx <= cfg_data;
                3'd1:    r_sk <= cfg_data;
                3'd2:    r_cx <= cfg_data;
                3'd3:    r_fy <= cfg_data;
                3'd4:    r_cy <= cfg_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s_fx <= '0; r_s_sk <= '0; r_s_cx <= '0; r_s_fy <= '0; r_s_cy <= '0;
            r_x <= '0; r_y <= '0; r_z <= '0;
            r_qx <= '0; r_qy <= '0; r_rx <= '0; r_ry <= '0; r_d <= '0;
            r_negx <= 1'b0; r_negy <= 1'b0; r_bad <= 1'b0;
            r_cnt <= '0;
            r_out_x <= '0; r_out_y <= '0; r_out_stat <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_x <= in_x; r_y <= in_y; r_z <= in_z;
                    r_s_fx <= r_fx; r_s_sk <= r_sk; r_s_cx <= r_cx;
                    r_s_fy <= r_fy; r_s_cy <= r_cy;
                end
                S_MAC: begin
                    r_cnt <= '0;
                    r_rx  <= '0;
                    r_ry  <= '0;
                    r_d   <= r_z;
                    r_bad <= w_zbad;
                    if (w_zbad) begin
                        r_qx <= '0; r_qy <= '0; r_negx <= 1'b0; r_negy <= 1'b0;
                    end else begin
                        r_qx   <= w_nx[NUM_W-1] ? -w_nx : w_nx;
                        r_qy   <= w_ny[NUM_W-1] ? -w_ny : w_ny;
                        r_negx <= w_nx[NUM_W-1];
                        r_negy <= w_ny[NUM_W-1];
                    end
                end
                S_DIV: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_rx  <= w_gex ? (w_tx[Z_W-1:0] - r_d) : w_tx[Z_W-1:0];
                    r_ry  <= w_gey ? (w_ty[Z_W-1:0] - r_d) : w_ty[Z_W-1:0];
                    r_qx  <= {r_qx[NUM_W-2:0], w_gex};
                    r_qy  <= {r_qy[NUM_W-2:0], w_gey};
                end
                S_POST: begin
                    r_out_x    <= w_cxo;
                    r_out_y    <= w_cyo;
                    r_out_stat <= {r_bad, w_clx | w_cly};
                end
                default: ;
            endcase
        end
    end

    assign out_x    = r_out_x;
    assign out_y    = r_out_y;
    assign out_stat = r_out_stat;
endmodule

// File: tb/tb_cam_project_3d2d.sv
// tb/tb_cam_project_3d2d.sv - directed self-checking bench for cam_project_3d2d
module tb_cam_project_3d2d;
    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_x, in_y;
    logic signed [15:0] in_z;
    logic               cfg_we;
    logic [2:0]         cfg_addr;
    logic [9:0]         cfg_data;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        out_x, out_y;
    logic [1:0]         out_stat;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cam_project_3d2d dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_stat(out_stat)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Counts cycles (sampled on negedge) from the accept cycle until out_valid.
    task automatic run(input string tag, input int x, input int y, input int z,
                       input int elat, input int ex, input int ey, input int es,
                       input bit inj_cfg, input bit hold_test);
        int n;
        logic [15:0] hx, hy;
        logic [1:0]  hs;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_in_ready"}, in_ready, 1);
        in_x = x;
        in_y = y;
        in_z = 16'(z);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 200) begin
            if (inj_cfg && n == 5) begin
                cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 10'd200;
            end
            @(negedge clk);
            cfg_we = 1'b0;
            n++;
        end
        check({tag, "_latency"}, n, elat);
        check({tag, "_out_x"}, out_x, ex);
        check({tag, "_out_y"}, out_y, ey);
        check({tag, "_stat"}, out_stat, es);
        if (hold_test) begin
            hx = out_x; hy = out_y; hs = out_stat;
            for (int i = 0; i < 10; i++) begin
                in_valid = 1'b1; in_x = 7; in_y = 7; in_z = 16'sd7;
                @(negedge clk);
                check({tag, "_hold_x"}, out_x, hx);
                check({tag, "_hold_y"}, out_y, hy);
                check({tag, "_hold_stat"}, out_stat, hs);
                check({tag, "_hold_in_ready"}, in_ready, 0);
                check({tag, "_hold_valid"}, out_valid, 1);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_post_in_ready"}, in_ready, 1);
        check({tag, "_post_valid"}, out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_x = 0; in_y = 0; in_z = 0;
        cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 10'd0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_x", out_x, 0);
        check("rst_out_y", out_y, 0);
        check("rst_stat", out_stat, 0);
        rst_n = 1'b1;

        cfg_we = 1'b1; cfg_addr = 3'd5; cfg_data = 10'd3;
        @(negedge clk);
        cfg_we = 1'b0;

        run("base",     100,  50, 1000, 65, 285, 161, 0, 1'b0, 1'b0);
        run("clamp_hi", 1000,  0,  100, 65, 479, 145, 1, 1'b0, 1'b0);
        run("clamp_lo", -1000, 0,  100, 65,   0, 145, 1, 1'b0, 1'b0);
        run("z_zero",   100,  50,    0,  3,   0,   0, 2, 1'b0, 1'b0);
        run("z_neg",    100,  50,   -5,  3,   0,   0, 2, 1'b0, 1'b0);
        run("cfg_mid",  100,  50, 1000, 65, 285, 161, 0, 1'b1, 1'b0);
        run("cfg_new",  100,  50, 1000, 65, 262, 161, 0, 1'b0, 1'b1);

        in_x = 100; in_y = 50; in_z = 16'sd1000; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_x", out_x, 0);
        check("mid_rst_out_y", out_y, 0);
        check("mid_rst_stat", out_stat, 0);
        run("after_rst", 100, 50, 1000, 65, 285, 161, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
